// File: rtl/dump_sequencer.sv
// Channel dump sequencer: fetches the calibration offset and gain for the
// selected channel from the EEPROM over SPI, then reads the capture RAM
// oldest-first, corrects each sample and sends it out through the UART.
module dump_sequencer #(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_i,
  input  logic [1:0]        dump_ch_i,
  input  logic [2:0]        ch1_AFEgain_i,
  input  logic [2:0]        ch2_AFEgain_i,
  input  logic [2:0]        ch3_AFEgain_i,
  input  logic [ADDR_W-1:0] trace_end_i,
  output logic              wrt_SPI_o,
  output logic [15:0]       SPI_data_o,
  output logic [2:0]        ss_o,
  input  logic              SPI_done_i,
  input  logic [7:0]        EEP_data_i,
  output logic              ram_ren_o,
  output logic [1:0]        ram_sel_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [7:0]        ram_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              trmt_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              dump_done_o
);

  // state   | meaning
  // IDLE    | waiting for a dump command
  // RD_OFF  | start EEPROM read of the calibration offset
  // WT_OFF  | wait for the offset byte
  // RD_GAIN | start EEPROM read of the calibration gain
  // WT_GAIN | wait for the gain byte
  // RD_RAM  | issue capture RAM read for the current address
  // CALC    | RAM data valid; register the corrected byte
  // TX      | start UART transmission of the corrected byte
  // WT_TX   | wait for UART completion, then next sample or finish
  // DONE    | one-cycle completion pulse
  // ERR_TX  | reserved channel requested; send the 0xEE error byte
  // ERR_WT  | wait for the error byte to complete
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_OFF  = 4'd1,
    WT_OFF  = 4'd2,
    RD_GAIN = 4'd3,
    WT_GAIN = 4'd4,
    RD_RAM  = 4'd5,
    CALC    = 4'd6,
    TX      = 4'd7,
    WT_TX   = 4'd8,
    DONE    = 4'd9,
    ERR_TX  = 4'd10,
    ERR_WT  = 4'd11
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [2:0]        SS_EEP    = 3'b100;
  localparam logic [7:0]        ERR_BYTE  = 8'hEE;

  state_t            state_q, state_d;
  logic [1:0]        ch_q;
  logic [2:0]        afe_q;
  logic [7:0]        offset_q;
  logic [7:0]        gain_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [7:0]        tx_data_q;

  logic [2:0]        afe_sel;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              cal_sel;
  logic [5:0]        eep_addr;
  logic signed [9:0] sum;
  logic [7:0]        clamped;
  logic [8:0]        scaled;
  logic [7:0]        corrected;

  // Pick the AFE gain of the requested channel; the reserved code never uses it.
  always_comb begin
    afe_sel = ch3_AFEgain_i;
    case (dump_ch_i)
      2'd0:    afe_sel = ch1_AFEgain_i;
      2'd1:    afe_sel = ch2_AFEgain_i;
      default: afe_sel = ch3_AFEgain_i;
    endcase
  end

  // Oldest sample sits just after the last written one; both addresses wrap.
  always_comb begin
    start_addr = (trace_end_i == LAST_ADDR) ? '0 : trace_end_i + ONE;
    next_addr  = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE;
  end

  // EEPROM location: channel, gain setting, then offset(0)/gain(1) select.
  always_comb begin
    cal_sel  = (state_q == RD_GAIN) || (state_q == WT_GAIN);
    eep_addr = {ch_q, afe_q, cal_sel};
  end

  // Sample correction: add signed offset, clamp to a byte, scale by gain/128, saturate.
  always_comb begin
    sum = $signed({2'b00, ram_rdata_i}) + $signed({{2{offset_q[7]}}, offset_q});
    if (sum[9])
      clamped = 8'h00;
    else if (sum[8])
      clamped = 8'hFF;
    else
      clamped = sum[7:0];
    scaled    = 9'(({8'h00, clamped} * {8'h00, gain_q}) >> 7);
    corrected = scaled[8] ? 8'hFF : scaled[7:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dump_i) state_d = (dump_ch_i == 2'd3) ? ERR_TX : RD_OFF;
      RD_OFF:  state_d = WT_OFF;
      WT_OFF:  if (SPI_done_i) state_d = RD_GAIN;
      RD_GAIN: state_d = WT_GAIN;
      WT_GAIN: if (SPI_done_i) state_d = RD_RAM;
      RD_RAM:  state_d = CALC;
      CALC:    state_d = TX;
      TX:      state_d = WT_TX;
      WT_TX:   if (tx_done_i) state_d = (cnt_q == LAST_ADDR) ? DONE : RD_RAM;
      DONE:    state_d = IDLE;
      ERR_TX:  state_d = ERR_WT;
      ERR_WT:  if (tx_done_i) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; SPI frame held through the wait state.
  always_comb begin
    wrt_SPI_o   = 1'b0;
    SPI_data_o  = 16'h0000;
    ss_o        = 3'b000;
    ram_ren_o   = 1'b0;
    ram_sel_o   = 2'b00;
    ram_raddr_o = '0;
    trmt_o      = 1'b0;
    dump_done_o = 1'b0;
    busy_o      = (state_q != IDLE);
    case (state_q)
      RD_OFF, RD_GAIN: begin
        wrt_SPI_o  = 1'b1;
        ss_o       = SS_EEP;
        SPI_data_o = {2'b00, eep_addr, 8'h00};
      end
      WT_OFF, WT_GAIN: begin
        ss_o       = SS_EEP;
        SPI_data_o = {2'b00, eep_addr, 8'h00};
      end
      RD_RAM: begin
        ram_ren_o   = 1'b1;
        ram_sel_o   = ch_q;
        ram_raddr_o = addr_q;
      end
      TX, ERR_TX: trmt_o      = 1'b1;
      DONE:       dump_done_o = 1'b1;
      default: ;
    endcase
  end

  assign tx_data_o = tx_data_q;

  // Dump context: channel, gain setting, calibration values, address and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q      <= 2'b00;
      afe_q     <= 3'b000;
      offset_q  <= 8'h00;
      gain_q    <= 8'h00;
      addr_q    <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (dump_i) begin
          ch_q   <= dump_ch_i;
          afe_q  <= afe_sel;
          addr_q <= start_addr;
          cnt_q  <= '0;
          if (dump_ch_i == 2'd3) tx_data_q <= ERR_BYTE;
        end
        WT_OFF:  if (SPI_done_i) offset_q <= EEP_data_i;
        WT_GAIN: if (SPI_done_i) gain_q   <= EEP_data_i;
        CALC:    tx_data_q <= corrected;
        WT_TX: if (tx_done_i && (cnt_q != LAST_ADDR)) begin
          cnt_q  <= cnt_q + ONE;
          addr_q <= next_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed bench for dump_sequencer with behavioural SPI/EEPROM, RAM and UART responders.
module tb_dump_sequencer;
  localparam int ENTRIES = 384;
  localparam int ADDR_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dump;
  logic [1:0]        dump_ch;
  logic [2:0]        ch1_AFEgain, ch2_AFEgain, ch3_AFEgain;
  logic [ADDR_W-1:0] trace_end;
  logic              wrt_SPI;
  logic [15:0]       SPI_data;
  logic [2:0]        ss;
  logic              SPI_done = 1'b0;
  logic [7:0]        EEP_data = 8'h00;
  logic              ram_ren;
  logic [1:0]        ram_sel;
  logic [ADDR_W-1:0] ram_raddr;
  logic [7:0]        ram_rdata = 8'h00;
  logic [7:0]        tx_data;
  logic              trmt;
  logic              tx_done = 1'b0;
  logic              busy;
  logic              dump_done;

  dump_sequencer #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .dump_i(dump), .dump_ch_i(dump_ch),
    .ch1_AFEgain_i(ch1_AFEgain), .ch2_AFEgain_i(ch2_AFEgain), .ch3_AFEgain_i(ch3_AFEgain),
    .trace_end_i(trace_end), .wrt_SPI_o(wrt_SPI), .SPI_data_o(SPI_data), .ss_o(ss),
    .SPI_done_i(SPI_done), .EEP_data_i(EEP_data), .ram_ren_o(ram_ren), .ram_sel_o(ram_sel),
    .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata), .tx_data_o(tx_data), .trmt_o(trmt),
    .tx_done_i(tx_done), .busy_o(busy), .dump_done_o(dump_done)
  );

  always #5 clk = ~clk;

  // Environment state
  logic [7:0]        ram_mem [ENTRIES];
  logic [7:0]        eep_off, eep_gain;
  logic              tx_auto;
  logic [7:0]        txlog   [4096];
  logic [ADDR_W-1:0] rdlog   [4096];
  logic [15:0]       spilog  [64];
  int                tx_n = 0, rd_n = 0, spi_n = 0, done_n = 0, ss_bad = 0;
  int                sdly = 0, tdly = 0;
  logic [1:0]        last_sel = 2'b00;

  // Responders and activity logs
  always @(posedge clk) begin
    SPI_done <= 1'b0;
    tx_done  <= 1'b0;
    if (wrt_SPI) begin
      spilog[spi_n] <= SPI_data;
      spi_n <= spi_n + 1;
      sdly  <= 3;
      if (ss !== 3'b100) ss_bad <= ss_bad + 1;
    end else if (sdly != 0) begin
      sdly <= sdly - 1;
      if (sdly == 1) begin
        SPI_done <= 1'b1;
        EEP_data <= SPI_data[8] ? eep_gain : eep_off;
        if (ss !== 3'b100 || SPI_data !== spilog[spi_n-1]) ss_bad <= ss_bad + 1;
      end
    end
    if (ram_ren) begin
      ram_rdata    <= ram_mem[ram_raddr];
      rdlog[rd_n]  <= ram_raddr;
      rd_n         <= rd_n + 1;
      last_sel     <= ram_sel;
    end
    if (trmt) begin
      txlog[tx_n] <= tx_data;
      tx_n <= tx_n + 1;
      if (tx_auto) tdly <= 4;
    end else if (tdly != 0) begin
      tdly <= tdly - 1;
      if (tdly == 1) tx_done <= 1'b1;
    end
    if (dump_done) done_n <= done_n + 1;
  end

  logic [63:0] outv;
  assign outv = {21'd0, wrt_SPI, SPI_data, ss, ram_ren, ram_sel, ram_raddr, tx_data, trmt, busy, dump_done};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] off, input logic [7:0] g);
    int s, p;
    s = int'(d) + int'($signed(off));
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    p = (s * int'(g)) / 128;
    if (p > 255) p = 255;
    return p[7:0];
  endfunction

  // Pulse dump, optionally pulse a second dump mid-run, and wait for dump_done.
  task automatic run_dump(input logic [1:0] ch, input int inject_at);
    int cyc;
    @(negedge clk);
    dump_ch = ch;
    dump    = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!dump_done && cyc < 8000) begin
      dump = (cyc == inject_at);
      if (cyc == inject_at) dump_ch = 2'd2;
      @(negedge clk);
      cyc++;
    end
    dump = 1'b0;
    chk("dump_done_timeout", (cyc < 8000), 1);
    @(negedge clk);
  endtask

  // Compare a whole dump against the correction model and wrapped address order.
  task automatic check_dump(input string tag, input int start, input int tx0, input int rd0);
    int a, bad_b, bad_a;
    bad_b = 0;
    bad_a = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      a = (start + i) % ENTRIES;
      if (txlog[tx0+i] !== model(ram_mem[a], eep_off, eep_gain)) bad_b++;
      if (rdlog[rd0+i] !== ADDR_W'(a)) bad_a++;
    end
    chk({tag, "_tx_count"}, tx_n - tx0, ENTRIES);
    chk({tag, "_rd_count"}, rd_n - rd0, ENTRIES);
    chk({tag, "_bytes_bad"}, bad_b, 0);
    chk({tag, "_addrs_bad"}, bad_a, 0);
  endtask

  initial begin
    int tx0, rd0, spi0, dn0, cyc;
    rst_n = 1'b0; dump = 1'b0; dump_ch = 2'd0;
    ch1_AFEgain = 3'd5; ch2_AFEgain = 3'd3; ch3_AFEgain = 3'd6;
    trace_end = 9'(ENTRIES - 1);
    eep_off = 8'h00; eep_gain = 8'h80; tx_auto = 1'b1;
    for (int i = 0; i < ENTRIES; i++) ram_mem[i] = i[7:0];
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("reset_outputs", outv, 64'd0);
    chk("reset_busy", busy, 0);

    // Unity calibration, channel 1, no wrap
    tx0 = tx_n; rd0 = rd_n; spi0 = spi_n; dn0 = done_n;
    run_dump(2'd1, -1);
    chk("t1_spi_count", spi_n - spi0, 2);
    chk("t1_spi_off_frame", spilog[spi0], 16'h1600);
    chk("t1_spi_gain_frame", spilog[spi0+1], 16'h1700);
    chk("t1_first_byte", txlog[tx0], 8'h00);
    chk("t1_byte_200", txlog[tx0+200], 8'd200);
    chk("t1_last_byte", txlog[tx0+ENTRIES-1], 8'h7F);
    check_dump("t1", 0, tx0, rd0);
    chk("t1_ram_sel", last_sel, 2'd1);
    chk("t1_done_count", done_n - dn0, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_ss_hold", ss_bad, 0);

    // Wrapped start address, second dump pulse mid-run must be ignored
    trace_end = 9'd10;
    tx0 = tx_n; rd0 = rd_n; spi0 = spi_n; dn0 = done_n;
    run_dump(2'd1, 500);
    chk("t2_first_raddr", rdlog[rd0], 9'd11);
    chk("t2_last_raddr", rdlog[rd0+ENTRIES-1], 9'd10);
    check_dump("t2", 11, tx0, rd0);
    chk("t2_spi_count", spi_n - spi0, 2);
    chk("t2_ram_sel", last_sel, 2'd1);
    chk("t2_done_count", done_n - dn0, 1);

    // Negative offset clamps to zero
    trace_end = 9'(ENTRIES - 1);
    eep_off = 8'hF6; eep_gain = 8'h80;
    ram_mem[0] = 8'd5; ram_mem[1] = 8'd200;
    tx0 = tx_n; rd0 = rd_n; spi0 = spi_n;
    run_dump(2'd0, -1);
    chk("a1_spi_off_frame", spilog[spi0], 16'h0A00);
    chk("a1_neg_clamp", txlog[tx0], 8'd0);
    chk("a1_rdata200", txlog[tx0+1], 8'd190);
    check_dump("a1", 0, tx0, rd0);

    // Large gain saturates
    eep_off = 8'h10; eep_gain = 8'hFF;
    tx0 = tx_n; rd0 = rd_n;
    run_dump(2'd0, -1);
    chk("a2_rdata5", txlog[tx0], 8'd41);
    chk("a2_saturate", txlog[tx0+1], 8'd255);
    check_dump("a2", 0, tx0, rd0);

    // Half gain
    eep_off = 8'h00; eep_gain = 8'h40;
    ram_mem[0] = 8'd100;
    tx0 = tx_n; rd0 = rd_n; spi0 = spi_n;
    run_dump(2'd2, -1);
    chk("a3_spi_gain_frame", spilog[spi0+1], 16'h2D00);
    chk("a3_half", txlog[tx0], 8'd50);
    chk("a3_rdata200", txlog[tx0+1], 8'd100);
    check_dump("a3", 0, tx0, rd0);
    chk("a3_ram_sel", last_sel, 2'd2);

    // Reserved channel: one error byte, no SPI or RAM activity
    tx0 = tx_n; rd0 = rd_n; spi0 = spi_n; dn0 = done_n;
    run_dump(2'd3, -1);
    chk("err_spi_count", spi_n - spi0, 0);
    chk("err_rd_count", rd_n - rd0, 0);
    chk("err_tx_count", tx_n - tx0, 1);
    chk("err_byte", txlog[tx0], 8'hEE);
    chk("err_done_count", done_n - dn0, 1);

    // Reset while waiting on the UART, then restart
    tx_auto = 1'b0;
    tx0 = tx_n; dn0 = done_n;
    @(negedge clk); dump_ch = 2'd1; dump = 1'b1;
    @(negedge clk); dump = 1'b0;
    cyc = 0;
    while (tx_n == tx0 && cyc < 200) begin @(negedge clk); cyc++; end
    chk("rst_trmt_timeout", (cyc < 200), 1);
    repeat (2) @(negedge clk);
    chk("rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", outv, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_auto = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", done_n - dn0, 0);
    chk("rst_idle_busy", busy, 0);
    eep_off = 8'h00; eep_gain = 8'h80;
    tx0 = tx_n; rd0 = rd_n; spi0 = spi_n; dn0 = done_n;
    run_dump(2'd0, -1);
    chk("rst_restart_frame", spilog[spi0], 16'h0A00);
    check_dump("rst", 0, tx0, rd0);
    chk("rst_done_count", done_n - dn0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dump_sequencer.md
Name: dump_sequencer

Overview:
- Sequences a channel dump after a DUMP_CH command is decoded.
- Fetches the per-channel, per-gain calibration offset and gain from the calibration EEPROM over the shared SPI master.
- Then walks the capture RAM for the selected channel in chronological order, corrects each sample, and streams the corrected bytes out through the UART transmitter one at a time.
- Sits between the command decoder, the SPI master, the capture RAMs and the UART.

Parameters:
- ENTRIES, 384, samples per channel capture buffer.
- ADDR_W, 9, capture RAM address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- dump  in  1  one-cycle start pulse from command decoder
- dump_ch  in  2  channel to dump (0..2 valid, 3 reserved)
- ch1_AFEgain, ch2_AFEgain, ch3_AFEgain  in  3 each  current AFE gain setting per channel
- trace_end  in  ADDR_W  address of the most recently written sample
- wrt_SPI  out  1  one-cycle SPI transaction start
- SPI_data  out  16  SPI frame
- ss  out  3  SPI slave select code
- SPI_done  in  1  SPI transaction complete pulse
- EEP_data  in  8  EEPROM read data, valid when SPI_done
- ram_ren  out  1  capture RAM read enable
- ram_sel  out  2  which channel RAM is read
- ram_raddr  out  ADDR_W  capture RAM read address
- ram_rdata  in  8  RAM data, valid the cycle after ram_ren
- tx_data  out  8  byte to UART
- trmt  out  1  one-cycle UART transmit start
- tx_done  in  1  UART byte complete pulse
- busy  out  1  high from accepted dump until dump_done
- dump_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset values: all outputs 0, state IDLE, latched offset/gain/channel/address/count all 0.
- States: IDLE, RD_OFF, WT_OFF, RD_GAIN, WT_GAIN, RD_RAM, CALC, TX, WT_TX, DONE, ERR_TX, ERR_WT.
- IDLE:
  - On dump, latch dump_ch, the selected chN_AFEgain, and start address (trace_end+1, wrapping ENTRIES-1 -> 0); clear the sample count.
  - dump_ch=3 goes to ERR_TX; otherwise RD_OFF.
  - dump asserted while busy is ignored.
- EEPROM address: addr[5:0] = {ch[1:0], gain[2:0], sel}; sel=0 selects offset, sel=1 selects gain.
- RD_OFF and RD_GAIN:
  - wrt_SPI=1 for one cycle; ss=3'b100; SPI_data={2'b00, addr[5:0], 8'h00}.
  - ss and SPI_data are held stable until the matching SPI_done.
  - Next state is WT_OFF / WT_GAIN.
- WT_OFF: on SPI_done, latch offset=EEP_data, go to RD_GAIN.
- WT_GAIN: on SPI_done, latch gain=EEP_data, go to RD_RAM.
- RD_RAM: ram_ren=1, ram_sel=ch, ram_raddr=current address; go to CALC.
- CALC: ram_rdata is valid; compute the corrected sample and register it into tx_data; go to TX.
- TX: trmt=1 for one cycle; go to WT_TX.
- WT_TX: on tx_done:
  - If count==ENTRIES-1, go to DONE.
  - Otherwise increment count, advance the address (wrapping ENTRIES-1 -> 0), and go to RD_RAM.
- DONE: dump_done=1 for one cycle, busy drops, go to IDLE.
- ERR_TX: tx_data=8'hEE, trmt=1, go to ERR_WT.
- ERR_WT: on tx_done, go to DONE.
- Correction arithmetic:
  - offset is signed 8-bit; sum = {2'b00, rdata} + sign-extended offset, 10-bit signed.
  - Clamp sum to 0..255.
  - Multiply by unsigned gain (8'h80 = 1.0) to a 16-bit product.
  - Shift right by 7, then saturate at 255.
- Exactly ENTRIES bytes are sent per valid dump, oldest sample first, ending at trace_end.
- SPI_done and tx_done arriving outside their wait states are ignored.
- busy=1 in every state except IDLE.
- Reset mid-dump aborts immediately to IDLE with reset values; no dump_done is produced.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0.
- dump_ch=1, ch2_AFEgain=3, trace_end=ENTRIES-1, EEP returns offset 0 then gain 8'h80, RAM[i]=i[7:0]:
  - SPI frames are 16'h0000|(6'b01_011_0<<8) and then with sel=1.
  - ENTRIES trmt pulses, bytes 0,1,2..., addresses 0..ENTRIES-1.
  - One dump_done.
- trace_end=10 -> first ram_raddr=11, last=10 after wrap through ENTRIES-1 -> 0; exactly ENTRIES reads.
- Arithmetic:
  - offset 8'hF6 (-10), rdata 5 -> tx_data 0.
  - offset 8'h10, gain 8'hFF, rdata 200 -> 255 (saturate).
  - offset 0, gain 8'h40, rdata 100 -> 50.
- dump_ch=3 -> no SPI or RAM activity; single byte 8'hEE; dump_done after tx_done.
- Second dump pulse mid-dump is ignored and the count is unchanged. rst_n low during WT_TX -> idle outputs at once; a later dump restarts from RD_OFF.
